// File: rtl/gate_unit_pkg.sv
// Shared types and constants for the gate unit arbiter.
package gate_unit_pkg;

  typedef enum logic [1:0] {
    OP_AND3  = 2'b00,
    OP_NAND3 = 2'b01,
    OP_INV   = 2'b10,
    OP_RSVD  = 2'b11
  } gate_op_t;

  localparam int GRANT_CNT_W = 16;

endpackage

// File: rtl/and3.sv
// Bitwise 3-input AND primitive.
module and3 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);

  assign y = a & b & c;

endmodule

// File: rtl/gate_eval.sv
// Combinational gate evaluator: AND3 / NAND3 / INV built from the and3/inv primitives.
module gate_eval
  import gate_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  gate_op_t     op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y,
  output logic         err
);

  logic [W-1:0] abc;
  logic [W-1:0] nabc;
  logic [W-1:0] na;

  and3 #(.W(W)) u_and3     (.a(a),   .b(b), .c(c), .y(abc));
  inv  #(.W(W)) u_inv_nand (.a(abc), .y(nabc));
  inv  #(.W(W)) u_inv_a    (.a(a),   .y(na));

  // Select the primitive output for the requested op; the reserved op yields zero and flags an error.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND3:  y = abc;
      OP_NAND3: y = nabc;
      OP_INV:   y = na;
      default:  err = 1'b1;
    endcase
  end

endmodule

// File: rtl/inv.sv
// Bitwise inverter primitive.
module inv #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = ~a;

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one gate evaluator among NREQ requesters, with a
// single registered result stage on a valid/ready response channel.
module gate_unit_arbiter
  import gate_unit_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [W*NREQ-1:0]      req_a,
  input  logic [W*NREQ-1:0]      req_b,
  input  logic [W*NREQ-1:0]      req_c,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [W-1:0]           rsp_y,
  output logic                   rsp_err,
  output logic [GRANT_CNT_W-1:0] grant_count
);

  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] winner;
  logic           found;
  logic           can_accept;
  logic           accept;
  gate_op_t       win_op;
  logic [W-1:0]   win_a;
  logic [W-1:0]   win_b;
  logic [W-1:0]   win_c;
  logic [W-1:0]   eval_y;
  logic           eval_err;

  // The result slot can take a new request when empty or being drained this cycle.
  assign can_accept = !rsp_valid || rsp_ready;
  assign accept     = found && can_accept;

  // Round-robin search starting just after the last granted requester, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last_grant) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // Only the winner sees ready, and only when the result slot is free.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  assign win_op = gate_op_t'(req_op[2*int'(winner) +: 2]);
  assign win_a  = req_a[W*int'(winner) +: W];
  assign win_b  = req_b[W*int'(winner) +: W];
  assign win_c  = req_c[W*int'(winner) +: W];

  gate_eval #(.W(W)) u_gate_eval (
    .op  (win_op),
    .a   (win_a),
    .b   (win_b),
    .c   (win_c),
    .y   (eval_y),
    .err (eval_err)
  );

  // Result register, priority pointer and grant counter; loads on accept, otherwise holds or drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid   <= 1'b0;
      rsp_y       <= '0;
      rsp_id      <= '0;
      rsp_err     <= 1'b0;
      grant_count <= '0;
      last_grant  <= IDW'(NREQ - 1);
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (accept) begin
        rsp_valid   <= 1'b1;
        rsp_y       <= eval_y;
        rsp_id      <= winner;
        rsp_err     <= eval_err;
        last_grant  <= winner;
        grant_count <= grant_count + GRANT_CNT_W'(1);
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Self-checking bench: behavioural model of the shared gate unit plus directed literal checks.
module tb_gate_unit_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_op = '0;
  logic [W*NREQ-1:0] req_a = '0;
  logic [W*NREQ-1:0] req_b = '0;
  logic [W*NREQ-1:0] req_c = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_y;
  logic              rsp_err;
  logic [15:0]       grant_count;

  always #5 clk = ~clk;

  gate_unit_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_c       (req_c),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_y       (rsp_y),
    .rsp_err     (rsp_err),
    .grant_count (grant_count)
  );

  int checks = 0;
  int failures = 0;

  // Requester side: each pending request and its payload.
  bit         p_valid[NREQ];
  logic [1:0] p_op[NREQ];
  logic [W-1:0] p_a[NREQ];
  logic [W-1:0] p_b[NREQ];
  logic [W-1:0] p_c[NREQ];

  // Model of the response channel and arbitration state.
  bit           m_valid;
  logic [W-1:0] m_y;
  int           m_id;
  bit           m_err;
  int           m_last;
  int           m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_y(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [W-1:0] c);
    case (op)
      2'd0:    return a & b & c;
      2'd1:    return ~(a & b & c);
      2'd2:    return ~a;
      default: return '0;
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]      = p_valid[i];
      req_op[2*i +: 2]  = p_op[i];
      req_a[W*i +: W]   = p_a[i];
      req_b[W*i +: W]   = p_b[i];
      req_c[W*i +: W]   = p_c[i];
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c);
    p_valid[i] = 1'b1;
    p_op[i] = op;
    p_a[i] = a;
    p_b[i] = b;
    p_c[i] = c;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_y = '0;
    m_id = 0;
    m_err = 1'b0;
    m_last = NREQ - 1;
    m_cnt = 0;
    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
  endtask

  // One clock cycle: entered and left at the falling edge; compares DUT against the model, then advances the model.
  task automatic cycle();
    bit              can;
    int              win;
    logic [NREQ-1:0] exp_ready;
    drive();
    #1;
    can = !m_valid || rsp_ready;
    win = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (m_last + k) % NREQ;
      if (win < 0 && p_valid[idx]) win = idx;
    end
    exp_ready = '0;
    if (win >= 0 && can) exp_ready[win] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check("grant_count", 32'(grant_count), 32'(m_cnt[15:0]));
    if (m_valid) begin
      check("rsp_y", 32'(rsp_y), 32'(m_y));
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    @(posedge clk);
    if (win >= 0 && can) begin
      m_y = ref_y(p_op[win], p_a[win], p_b[win], p_c[win]);
      m_id = win;
      m_err = (p_op[win] == 2'd3);
      m_valid = 1'b1;
      m_last = win;
      m_cnt = (m_cnt + 1) % 65536;
      p_valid[win] = 1'b0;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear immediately.
  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
    drive();
    #3 reset_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_y", 32'(rsp_y), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_grant_count", 32'(grant_count), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NREQ; i++) begin
      p_op[i] = '0; p_a[i] = '0; p_b[i] = '0; p_c[i] = '0;
    end
    drive();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) cycle();

    // Reset mid-run with nothing pending.
    do_reset();

    // Single request from requester 2: AND3 0xFF & 0x0F & 0x3C = 0x0C.
    rsp_ready = 1'b1;
    set_req(2, 2'd0, 8'hFF, 8'h0F, 8'h3C);
    drive();
    #1 check("single_req_ready", 32'(req_ready), 32'b0100);
    cycle();
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_y", 32'(rsp_y), 32'h0C);
    check("single_id", 32'(rsp_id), 32'd2);
    check("single_err", 32'(rsp_err), 32'd0);
    cycle();
    check("drain_valid", 32'(rsp_valid), 32'd0);

    // All four requesting continuously: grants 0,1,2,3,0,1 one per cycle.
    do_reset();
    rsp_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 2'(i), 8'(16*i + j), 8'hFF, 8'hFF);
      cycle();
      check("rr_id", 32'(rsp_id), 32'(j % 4));
      check("rr_count", 32'(grant_count), 32'(j + 1));
    end

    // Backpressure: NAND3 of 0xF0 held for 3 cycles, then reload with no bubble.
    do_reset();
    rsp_ready = 1'b1;
    set_req(1, 2'd1, 8'hF0, 8'hF0, 8'hF0);
    cycle();
    rsp_ready = 1'b0;
    set_req(3, 2'd0, 8'h33, 8'hFF, 8'h0F);
    for (int j = 0; j < 3; j++) begin
      drive();
      #1;
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_y", 32'(rsp_y), 32'h0F);
      check("bp_id", 32'(rsp_id), 32'd1);
      cycle();
    end
    rsp_ready = 1'b1;
    cycle();
    check("bp_reload_valid", 32'(rsp_valid), 32'd1);
    check("bp_reload_id", 32'(rsp_id), 32'd3);
    check("bp_reload_y", 32'(rsp_y), 32'h03);

    // INV and reserved ops.
    set_req(0, 2'd2, 8'hA5, 8'h12, 8'h34);
    cycle();
    check("inv_y", 32'(rsp_y), 32'h5A);
    check("inv_err", 32'(rsp_err), 32'd0);
    set_req(1, 2'd3, 8'hFF, 8'hFF, 8'hFF);
    cycle();
    check("rsvd_y", 32'(rsp_y), 32'h00);
    check("rsvd_err", 32'(rsp_err), 32'd1);
    check("rsvd_id", 32'(rsp_id), 32'd1);

    // Randomized traffic with backpressure, early drops and a reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (p_valid[i] && $urandom_range(15) == 0) p_valid[i] = 1'b0;
        else if (!p_valid[i] && $urandom_range(1) == 1)
          set_req(i, 2'($urandom_range(3)), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      rsp_ready = ($urandom_range(3) != 0);
      if (n == 1500) do_reset();
      else cycle();
    end

    // Counter wrap: 65536 back-to-back accepts bring grant_count back to zero.
    do_reset();
    rsp_ready = 1'b1;
    for (int n = 0; n < 65536; n++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 2'(n % 4), 8'(n), 8'(n >> 8), 8'hFF);
      cycle();
      if (n == 65534) check("wrap_ffff", 32'(grant_count), 32'hFFFF);
    end
    check("wrap_zero", 32'(grant_count), 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_unit_arbiter.md
Name: gate_unit_arbiter

Overview:
- Shares one bitwise 3-input gate evaluator (AND3 / NAND3 / INV) among NREQ requesters.
- Each requester presents an op plus operands under a valid/ready handshake.
- A round-robin arbiter grants one request per cycle into a single registered result stage.
- Results return on one response channel, tagged with the requester id.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 8, operand/result width in bits; bitwise operation.
- IDW, $clog2(NREQ), requester id width (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; one-hot or zero
- req_op  input  2*NREQ  op per requester, slice i = [2i+1:2i]
- req_a  input  W*NREQ  operand a, slice i = [W*i+W-1:W*i]
- req_b  input  W*NREQ  operand b, same slicing
- req_c  input  W*NREQ  operand c, same slicing
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  IDW  index of the requester that produced the result
- rsp_y  output  W  result
- rsp_err  output  1  reserved op was issued
- grant_count  output  16  total accepted requests; wraps 0xFFFF -> 0

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_y=0, rsp_id=0, rsp_err=0, grant_count=0, last_grant=NREQ-1, so requester 0 has top priority first.
- Op encoding:
  - 00 AND3: y = a & b & c.
  - 01 NAND3: y = ~(a & b & c).
  - 10 INV: y = ~a; b and c are ignored.
  - 11 reserved: y = 0, rsp_err = 1.
- Slot free: can_accept = !rsp_valid | rsp_ready.
- Arbitration (combinational):
  - Search from last_grant+1 upward, wrapping modulo NREQ.
  - The first i with req_valid[i]=1 wins.
  - req_ready[winner] = can_accept; every other bit of req_ready = 0.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer on requester i occurs when req_valid[i] & req_ready[i] at a clock edge. On that edge:
  - The result register loads y, id=i and err.
  - rsp_valid becomes 1.
  - last_grant becomes i.
  - grant_count increments.
- Latency: exactly 1 cycle from accept edge to rsp_valid high.
- Throughput: one result per cycle while rsp_ready stays high.
- Backpressure: while rsp_valid & !rsp_ready, rsp_y, rsp_id and rsp_err hold stable and req_ready is all zeros.
- Response drain: when rsp_valid & rsp_ready and there is no new accept, rsp_valid goes to 0 on the edge. rsp_y, rsp_id and rsp_err keep their last values (don't-care).
- Simultaneous drain and accept in the same cycle: the register reloads and rsp_valid stays 1, with no bubble.
- Requester holding: a requester keeps req_valid and its payload stable until accepted. Dropping req_valid early is permitted; such a request is simply never served.
- No requests pending: last_grant is unchanged and no counter activity occurs.
- Fairness: a continuously requesting requester waits at most NREQ-1 grants.
- Reset mid-operation: a pending result is discarded, rsp_valid goes 0 immediately (asynchronously) and priority returns to requester 0.

Decomposition:
- Package gate_unit_pkg holds:
  - typedef enum logic [1:0] gate_op_t {OP_AND3, OP_NAND3, OP_INV, OP_RSVD}.
  - Localparam GRANT_CNT_W = 16.
- Sub-module gate_eval (combinational):
  - Ports: op, a, b, c -> y, err.
  - Built from the team's existing and3/inv primitives, applied bitwise.
- The round-robin pick and the result register stay in gate_unit_arbiter.

Test Plan:
- Reset state, no traffic: NREQ=4, reset_n pulsed low mid-run -> all outputs 0, grant_count=0, req_ready=0000.
- Single request: req 2 sends AND3, a=0xFF, b=0x0F, c=0x3C, rsp_ready=1 -> req_ready=0100 that cycle. Next cycle rsp_valid=1, rsp_y=0x0C, rsp_id=2, rsp_err=0.
- All four requesting continuously with rsp_ready=1 -> grant order 0,1,2,3,0,1; one result per cycle; grant_count increments by 1 per cycle.
- Backpressure: rsp_ready=0 for 3 cycles with result NAND3 a=b=c=0xF0 (y=0x0F) -> rsp_y/rsp_id held; req_ready=0000. On release with the next request pending, reload occurs with no bubble cycle.
- INV and reserved ops:
  - INV a=0xA5 -> y=0x5A, err=0.
  - op=11 -> y=0x00, err=1.
- Counter wrap: force 65536 accepts -> grant_count reads 0x0000 after the 65536th.
